ft600_device_responder: RTL and testbench

- Chip-side (responder) model of the FT600 245-FIFO-mode bus. It is the counterpart of the FPGA-side ft600_mode245 master.
- Drives ft_rxf_n/ft_txe_n and the read data bus. Accepts bus writes.
- Bridges the bus to two host-side valid/ready streams through internal FIFOs.
- Used for loopback benches and on-board self-test, with a second FPGA acting as the "USB chip"; the whole block runs in the ft_clk domain, connected here as clk.

---
 rtl/ft600_pkg.sv | 20 ++
 rtl/ft600_sync_fifo.sv | 59 +++++
 rtl/ft600_device_responder.sv | 187 ++++++++++++++++++
 tb/tb_ft600_device_responder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft600_pkg.sv
// Shared types for the FT600 245-mode responder: bus word layout and read-side FSM states.
package ft600_pkg;

  localparam int FT_DATA_W = 16;
  localparam int FT_BE_W   = 2;
  localparam int FT_WORD_W = FT_DATA_W + FT_BE_W;

  // Byte enables ride in the upper bits so {be, data} concatenations map directly.
  typedef struct packed {
    logic [FT_BE_W-1:0]   be;
    logic [FT_DATA_W-1:0] data;
  } ft_word_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_OE   = 2'd1,
    RD_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ft600_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// Push while full and pop while empty are ignored.
module ft600_sync_fifo #(
  parameter int AW = 4,
  parameter int W  = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_full_next
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic [AW:0]  w_wptr_nxt;
  logic [AW:0]  w_rptr_nxt;
  logic         w_push;
  logic         w_pop;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  assign w_wptr_nxt = r_wptr + {{AW{1'b0}}, w_push};
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_pop};

  // Lets the owner register a flag that already reflects this edge's push/pop.
  assign o_full_next = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= w_wptr_nxt;
      r_rptr <= w_rptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ft600_device_responder.sv
// Chip-side FT600 245-FIFO-mode responder: serves FPGA reads/writes on the bus
// from two internal FIFOs bridged to host-side valid/ready streams.
module ft600_device_responder
  import ft600_pkg::*;
#(
  parameter int D2F_AW = 4,
  parameter int F2D_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [FT_DATA_W-1:0] host_in_data,
  input  logic [FT_BE_W-1:0]   host_in_be,
  input  logic                 host_in_valid,
  output logic                 host_in_ready,
  output logic [FT_DATA_W-1:0] host_out_data,
  output logic [FT_BE_W-1:0]   host_out_be,
  output logic                 host_out_valid,
  input  logic                 host_out_ready,
  input  logic [FT_DATA_W-1:0] ft_data_i,
  output logic [FT_DATA_W-1:0] ft_data_o,
  input  logic [FT_BE_W-1:0]   ft_be_i,
  output logic [FT_BE_W-1:0]   ft_be_o,
  output logic                 ft_data_oe,
  output logic                 ft_rxf_n,
  output logic                 ft_txe_n,
  input  logic                 ft_oe_n,
  input  logic                 ft_rd_n,
  input  logic                 ft_wr_n,
  output logic                 err_underrun,
  output logic                 err_overrun,
  output logic                 err_contention
);

  // Host streams: a word transfers on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data is stable while valid.

  ft_word_t  w_d2f_wdata;
  ft_word_t  w_d2f_head;
  logic      w_d2f_full;
  logic      w_d2f_empty;
  logic      w_d2f_full_next;
  logic      w_d2f_push;
  logic      w_d2f_pop;

  ft_word_t  w_f2d_wdata;
  ft_word_t  w_f2d_head;
  logic      w_f2d_full;
  logic      w_f2d_empty;
  logic      w_f2d_full_next;
  logic      w_f2d_push;
  logic      w_f2d_pop;

  rd_state_e r_rd_state;
  logic      r_data_oe;
  logic      r_rxf_n;
  logic      r_txe_n;
  logic      r_host_in_ready;
  logic      r_err_underrun;
  logic      r_err_overrun;
  logic      r_err_contention;
  logic      w_rd_strobe;

  assign w_rd_strobe = (r_rd_state == RD_DATA) && !ft_rd_n;

  assign w_d2f_wdata = {host_in_be, host_in_data};
  assign w_d2f_push  = host_in_valid & r_host_in_ready & ~w_d2f_full;
  assign w_d2f_pop   = w_rd_strobe & ~w_d2f_empty;

  // A write seen while the FPGA also asserts oe_n is a bus fight and is dropped.
  assign w_f2d_wdata = {ft_be_i, ft_data_i};
  assign w_f2d_push  = !ft_wr_n & !r_txe_n & ft_oe_n & ~w_f2d_full;
  assign w_f2d_pop   = ~w_f2d_empty & host_out_ready;

  ft600_sync_fifo #(
    .AW (D2F_AW),
    .W  (FT_WORD_W)
  ) u_d2f_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_d2f_push),
    .i_wdata     (w_d2f_wdata),
    .i_pop       (w_d2f_pop),
    .o_rdata     (w_d2f_head),
    .o_full      (w_d2f_full),
    .o_empty     (w_d2f_empty),
    .o_full_next (w_d2f_full_next)
  );

  ft600_sync_fifo #(
    .AW (F2D_AW),
    .W  (FT_WORD_W)
  ) u_f2d_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_f2d_push),
    .i_wdata     (w_f2d_wdata),
    .i_pop       (w_f2d_pop),
    .o_rdata     (w_f2d_head),
    .o_full      (w_f2d_full),
    .o_empty     (w_f2d_empty),
    .o_full_next (w_f2d_full_next)
  );

  // The OE state is the one-cycle bus turnaround before data is valid to sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_data_oe  <= 1'b0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (!ft_oe_n) begin
            r_rd_state <= RD_OE;
            r_data_oe  <= 1'b1;
          end
        end
        RD_OE: begin
          if (!ft_oe_n) begin
            r_rd_state <= RD_DATA;
            r_data_oe  <= 1'b1;
          end else begin
            r_rd_state <= RD_IDLE;
            r_data_oe  <= 1'b0;
          end
        end
        RD_DATA: begin
          if (ft_oe_n) begin
            r_rd_state <= RD_IDLE;
            r_data_oe  <= 1'b0;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
          r_data_oe  <= 1'b0;
        end
      endcase
    end
  end

  // rxf_n samples the settled empty flag, giving pushed data a cycle before it is
  // advertised; txe_n and host_in_ready track the post-edge fill so they never lag a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxf_n         <= 1'b1;
      r_txe_n         <= 1'b1;
      r_host_in_ready <= 1'b0;
    end else begin
      r_rxf_n         <= w_d2f_empty;
      r_txe_n         <= w_f2d_full_next;
      r_host_in_ready <= ~w_d2f_full_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_underrun   <= 1'b0;
      r_err_overrun    <= 1'b0;
      r_err_contention <= 1'b0;
    end else begin
      if (w_rd_strobe && w_d2f_empty) begin
        r_err_underrun <= 1'b1;
      end
      if (!ft_wr_n && r_txe_n) begin
        r_err_overrun <= 1'b1;
      end
      if (!ft_oe_n && !ft_wr_n) begin
        r_err_contention <= 1'b1;
      end
    end
  end

  assign ft_data_oe = r_data_oe;
  assign ft_data_o  = (r_data_oe && !w_d2f_empty) ? w_d2f_head.data : '0;
  assign ft_be_o    = (r_data_oe && !w_d2f_empty) ? w_d2f_head.be : '0;
  assign ft_rxf_n   = r_rxf_n;
  assign ft_txe_n   = r_txe_n;

  assign host_in_ready  = r_host_in_ready;
  assign host_out_valid = ~w_f2d_empty;
  assign host_out_data  = w_f2d_head.data;
  assign host_out_be    = w_f2d_head.be;

  assign err_underrun   = r_err_underrun;
  assign err_overrun    = r_err_overrun;
  assign err_contention = r_err_contention;

endmodule

// File: tb/tb_ft600_device_responder.sv
// Bench for ft600_device_responder: queue-based bus model checked every cycle,
// host-egress scoreboard, and directed FT600 read/write/error/reset scenarios.
module tb_ft600_device_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] host_in_data;
  logic [1:0]  host_in_be;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [15:0] host_out_data;
  logic [1:0]  host_out_be;
  logic        host_out_valid;
  logic        host_out_ready;
  logic [15:0] ft_data_i;
  logic [15:0] ft_data_o;
  logic [1:0]  ft_be_i;
  logic [1:0]  ft_be_o;
  logic        ft_data_oe;
  logic        ft_rxf_n;
  logic        ft_txe_n;
  logic        ft_oe_n;
  logic        ft_rd_n;
  logic        ft_wr_n;
  logic        err_underrun;
  logic        err_overrun;
  logic        err_contention;

  int n_checks = 0;
  int n_fail   = 0;
  logic [17:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ft600_device_responder #(
    .D2F_AW (4),
    .F2D_AW (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_in_data   (host_in_data),
    .host_in_be     (host_in_be),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_out_data  (host_out_data),
    .host_out_be    (host_out_be),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .ft_data_i      (ft_data_i),
    .ft_data_o      (ft_data_o),
    .ft_be_i        (ft_be_i),
    .ft_be_o        (ft_be_o),
    .ft_data_oe     (ft_data_oe),
    .ft_rxf_n       (ft_rxf_n),
    .ft_txe_n       (ft_txe_n),
    .ft_oe_n        (ft_oe_n),
    .ft_rd_n        (ft_rd_n),
    .ft_wr_n        (ft_wr_n),
    .err_underrun   (err_underrun),
    .err_overrun    (err_overrun),
    .err_contention (err_contention)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Two plain queues plus a count of consecutive edges with oe_n low.
  logic [17:0] m_d2f[$];
  logic [17:0] m_f2d[$];
  int          m_oe_cnt;
  logic        m_rxf_n, m_txe_n, m_in_ready;
  logic        m_eu, m_eo, m_ec;

  always @(posedge clk or negedge rst_n) begin : model
    bit rd_strobe, d2f_push, d2f_pop, f2d_push, f2d_pop;
    if (!rst_n) begin
      m_d2f.delete();
      m_f2d.delete();
      m_oe_cnt   = 0;
      m_rxf_n    = 1'b1;
      m_txe_n    = 1'b1;
      m_in_ready = 1'b0;
      m_eu = 1'b0;
      m_eo = 1'b0;
      m_ec = 1'b0;
    end else begin
      rd_strobe = (m_oe_cnt >= 2) && !ft_rd_n;
      d2f_pop   = rd_strobe && (m_d2f.size() > 0);
      d2f_push  = host_in_valid && m_in_ready;
      f2d_push  = !ft_wr_n && !m_txe_n && ft_oe_n;
      f2d_pop   = (m_f2d.size() > 0) && host_out_ready;
      if (rd_strobe && m_d2f.size() == 0) m_eu = 1'b1;
      if (!ft_wr_n && m_txe_n) m_eo = 1'b1;
      if (!ft_wr_n && !ft_oe_n) m_ec = 1'b1;
      m_rxf_n = (m_d2f.size() == 0);
      if (d2f_pop) void'(m_d2f.pop_front());
      if (d2f_push) m_d2f.push_back({host_in_be, host_in_data});
      if (f2d_pop) void'(m_f2d.pop_front());
      if (f2d_push) m_f2d.push_back({ft_be_i, ft_data_i});
      m_txe_n    = (m_f2d.size() == 16);
      m_in_ready = (m_d2f.size() != 16);
      m_oe_cnt   = ft_oe_n ? 0 : ((m_oe_cnt < 2) ? m_oe_cnt + 1 : 2);
    end
  end

  always @(negedge clk) begin : compare
    logic [17:0] h;
    if (rst_n) begin
      h = (m_oe_cnt >= 1 && m_d2f.size() > 0) ? m_d2f[0] : 18'h0;
      check("m_rxf_n", ft_rxf_n, m_rxf_n);
      check("m_txe_n", ft_txe_n, m_txe_n);
      check("m_data_oe", ft_data_oe, m_oe_cnt >= 1);
      check("m_data_o", ft_data_o, h[15:0]);
      check("m_be_o", ft_be_o, h[17:16]);
      check("m_host_in_ready", host_in_ready, m_in_ready);
      check("m_host_out_valid", host_out_valid, m_f2d.size() > 0);
      if (m_f2d.size() > 0) begin
        h = m_f2d[0];
        check("m_host_out_word", {host_out_be, host_out_data}, h);
      end
      check("m_err_underrun", err_underrun, m_eu);
      check("m_err_overrun", err_overrun, m_eo);
      check("m_err_contention", err_contention, m_ec);
    end
  end

  // ---------------- scoreboard on host egress ----------------
  always @(negedge clk) begin
    if (rst_n && host_out_valid && host_out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL host_out_extra: got %0h expected nothing", {host_out_be, host_out_data});
      end else begin
        check("host_out_order", {host_out_be, host_out_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic host_push(input logic [15:0] d, input logic [1:0] be);
    host_in_data  = d;
    host_in_be    = be;
    host_in_valid = 1'b1;
    tick();
    host_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    host_out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
    check("drain_remaining", exp_q.size(), 0);
    host_out_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [15:0] rd_exp [5];
    rd_exp[0] = 16'h1234; rd_exp[1] = 16'hA001; rd_exp[2] = 16'hA002;
    rd_exp[3] = 16'hA003; rd_exp[4] = 16'hA004;

    rst_n = 1'b0;
    host_in_data = '0; host_in_be = '0; host_in_valid = 1'b0; host_out_ready = 1'b0;
    ft_data_i = '0; ft_be_i = '0; ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1;
    tick(2);

    check("rst_rxf_n", ft_rxf_n, 1);
    check("rst_txe_n", ft_txe_n, 1);
    check("rst_data_oe", ft_data_oe, 0);
    check("rst_data_o", ft_data_o, 0);
    check("rst_be_o", ft_be_o, 0);
    check("rst_host_in_ready", host_in_ready, 0);
    check("rst_host_out_valid", host_out_valid, 0);
    check("rst_errs", {err_underrun, err_overrun, err_contention}, 0);

    rst_n = 1'b1;
    tick();
    check("txe_after_release", ft_txe_n, 0);
    check("ready_after_release", host_in_ready, 1);

    // rxf_n must fall exactly two edges after the push is presented.
    host_push(16'h1234, 2'b11);
    check("rxf_latency_1", ft_rxf_n, 1);
    tick();
    check("rxf_latency_2", ft_rxf_n, 0);

    // Read burst: 1234 then A001..A004.
    for (int i = 1; i <= 4; i++) host_push(16'hA000 + 16'(i), 2'b11);
    ft_oe_n = 1'b0;
    tick();
    check("oe_turnaround", ft_data_oe, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rd_burst_data", ft_data_o, rd_exp[i]);
      check("rd_burst_be", ft_be_o, 2'b11);
      ft_rd_n = 1'b0;
      tick();
    end
    ft_rd_n = 1'b1;
    check("rd_empty_bus_zero", ft_data_o, 0);
    ft_oe_n = 1'b1;
    tick();
    check("rd_rxf_high", ft_rxf_n, 1);
    check("rd_oe_released", ft_data_oe, 0);
    check("rd_no_underrun", err_underrun, 0);

    // Write fill: 17 strobes, the last one hits a full FIFO.
    host_out_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      check("fill_txe_before", ft_txe_n, i == 16);
      ft_data_i = 16'hB000 + 16'(i);
      ft_be_i   = 2'b11;
      ft_wr_n   = 1'b0;
      if (i < 16) exp_q.push_back({2'b11, 16'hB000 + 16'(i)});
      tick();
    end
    ft_wr_n = 1'b1;
    check("fill_txe_full", ft_txe_n, 1);
    check("fill_overrun", err_overrun, 1);
    drain(40);

    // Simultaneous write and drain for 50 cycles.
    host_out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      check("stream_txe_low", ft_txe_n, 0);
      ft_data_i = 16'hC000 + 16'(i);
      ft_be_i   = 2'(i);
      ft_wr_n   = 1'b0;
      exp_q.push_back({2'(i), 16'hC000 + 16'(i)});
      tick();
    end
    ft_wr_n = 1'b1;
    drain(10);

    // Underrun: read strobe in DATA with nothing buffered.
    ft_oe_n = 1'b0;
    tick(2);
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1;
    check("underrun_set", err_underrun, 1);
    check("underrun_rxf", ft_rxf_n, 1);
    ft_oe_n = 1'b1;
    tick();

    // Contention: one good write, then a write overlapping oe_n that must be dropped.
    ft_data_i = 16'hE001; ft_be_i = 2'b01; ft_wr_n = 1'b0;
    exp_q.push_back({2'b01, 16'hE001});
    tick();
    ft_data_i = 16'hD00D; ft_be_i = 2'b11; ft_oe_n = 1'b0;
    tick();
    ft_wr_n = 1'b1; ft_oe_n = 1'b1;
    check("contention_set", err_contention, 1);
    tick();
    drain(10);
    check("contention_no_push", host_out_valid, 0);

    // Async reset in the middle of a read burst.
    for (int i = 1; i <= 4; i++) host_push(16'hF000 + 16'(i), 2'b01);
    tick();
    ft_oe_n = 1'b0;
    tick(2);
    ft_rd_n = 1'b0;
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_oe", ft_data_oe, 0);
    check("async_rst_rxf", ft_rxf_n, 1);
    check("async_rst_data", ft_data_o, 0);
    check("async_rst_ready", host_in_ready, 0);
    ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_rxf", ft_rxf_n, 1);
    check("post_rst_out_valid", host_out_valid, 0);
    check("post_rst_errs", {err_underrun, err_overrun, err_contention}, 0);

    // Only the new word is visible; nothing from the aborted burst remains.
    host_push(16'h5A5A, 2'b10);
    tick();
    ft_oe_n = 1'b0;
    tick(2);
    check("post_rst_fresh_data", ft_data_o, 16'h5A5A);
    check("post_rst_fresh_be", ft_be_o, 2'b10);
    ft_oe_n = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
